// File: rtl/uart_tx_engine.sv
// ============================================================================
// uart_tx_engine
// ----------------------------------------------------------------------------
// Purpose:
//   Transmit half of a UART. Characters are queued in a small synchronous
//   FIFO and serialised onto tx_serial as 8N1-style frames: one start bit (0),
//   DATA_WIDTH data bits sent LSB first, then STOP_BITS stop bits (1). Bit
//   timing comes from an external oversample strobe: every bit lasts exactly
//   OVERSAMPLE_RATE sample_tick pulses. Frames run back-to-back while the FIFO
//   holds data, with no idle gap between them.
//
// Parameters:
//   FIFO_DEPTH       TX FIFO entries (power of 2, at least 2)
//   DATA_WIDTH       bits per character
//   OVERSAMPLE_RATE  sample_ticks per bit
//   STOP_BITS        stop bits per frame (1 or 2)
//
// Ports:
//   uart_clk        in   clock
//   uart_rst_n      in   asynchronous, active-low reset
//   sample_tick     in   one-cycle oversample strobe
//   wr_data         in   character to queue            [DATA_WIDTH]
//   wr_en           in   push request
//   fifo_clear      in   synchronous FIFO flush (also clears overflow_error)
//   break_req       in   line break request (only with UART_TX_BREAK_EN)
//   tx_serial       out  serial line, idle high, driven from a flop
//   wr_full         out  FIFO full
//   tx_empty        out  FIFO empty
//   tx_level        out  FIFO occupancy                [$clog2(FIFO_DEPTH)+1]
//   tx_active       out  frame (or break) in progress
//   overflow_error  out  sticky: a push was dropped because the FIFO was full
//
// Optional feature:
//   Define UART_TX_BREAK_EN to add the break_req input and a BREAK state that
//   holds the line low. A break request is honoured only from IDLE or at the
//   end of a frame, so it never cuts a character short, and it wins over
//   starting the next queued character.
// ============================================================================

module uart_tx_engine #(
    parameter int FIFO_DEPTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int OVERSAMPLE_RATE = 16,
    parameter int STOP_BITS       = 1
) (
    input  logic                            uart_clk,
    input  logic                            uart_rst_n,
    input  logic                            sample_tick,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            wr_en,
    input  logic                            fifo_clear,
`ifdef UART_TX_BREAK_EN
    input  logic                            break_req,
`endif
    output logic                            tx_serial,
    output logic                            wr_full,
    output logic                            tx_empty,
    output logic [$clog2(FIFO_DEPTH):0]     tx_level,
    output logic                            tx_active,
    output logic                            overflow_error
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int TICK_W   = (OVERSAMPLE_RATE > 1) ? $clog2(OVERSAMPLE_RATE) : 1;
    // One bit counter serves both the data bits and the stop bits, so it is
    // sized for whichever of the two runs longer.
    localparam int BITS_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int BIT_W    = (BITS_MAX > 1) ? $clog2(BITS_MAX) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE_RATE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                 state_q,    state_d;
    logic [TICK_W-1:0]      tickCnt_q,  tickCnt_d;
    logic [BIT_W-1:0]       bitCnt_q,   bitCnt_d;
    logic [DATA_WIDTH-1:0]  shift_q,    shift_d;
    logic                   txSerial_q, txSerial_d;

    logic [PTR_W-1:0]       wrPtr_q,    wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q,    rdPtr_d;
    logic [LVL_W-1:0]       level_q,    level_d;
    logic                   overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0]  fifoMem_q [FIFO_DEPTH];

    logic                   pushAccept;
    logic                   popFifo;
    logic                   bitDone;
    logic                   fifoEmpty;
    logic                   fifoFull;
    logic [DATA_WIDTH-1:0]  headData;

    // ------------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------------
    // Full and empty come straight from the registered occupancy, so a push
    // and a pop in the same cycle are judged against the level at the start
    // of that cycle: a push into a full FIFO is dropped even if the engine
    // frees a slot in the very same cycle.
    assign fifoFull  = (level_q == LVL_FULL);
    assign fifoEmpty = (level_q == '0);
    assign headData  = fifoMem_q[rdPtr_q];

    // A push during a flush is simply discarded; it is not an overflow.
    assign pushAccept = wr_en && !fifoFull && !fifo_clear;

    // ------------------------------------------------------------------------
    // FIFO storage. No reset: contents are only meaningful between the
    // pointers, and those are reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge uart_clk) begin
        if (pushAccept) begin
            fifoMem_q[wrPtr_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointer, occupancy and overflow next-state logic.
    // A flush wins over everything, but a pop in the flush cycle has already
    // copied the head entry into the shift register, so that character is
    // still sent in full.
    // ------------------------------------------------------------------------
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (fifo_clear) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pushAccept) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (popFifo) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(pushAccept) - LVL_W'(popFifo);
            if (wr_en && fifoFull) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM next-state logic.
    // The tick counter only moves on sample_tick, and a bit ends on the tick
    // that finds it at OVERSAMPLE_RATE-1. Loading a character always clears
    // both counters so the start bit gets its full length.
    // ------------------------------------------------------------------------
    assign bitDone = sample_tick && (tickCnt_q == TICK_LAST);

    always_comb begin
        state_d   = state_q;
        tickCnt_d = tickCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        popFifo   = 1'b0;

        case (state_q)
            IDLE: begin
                tickCnt_d = '0;
                bitCnt_d  = '0;
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_d = BREAK;
                end else
`endif
                if (!fifoEmpty) begin
                    popFifo = 1'b1;
                    shift_d = headData;
                    state_d = START;
                end
            end

            START: begin
                if (sample_tick) begin
                    tickCnt_d = bitDone ? '0 : tickCnt_q + TICK_W'(1);
                end
                if (bitDone) begin
                    bitCnt_d = '0;
                    state_d  = DATA;
                end
            end

            // The line always shows shift_q[0], so shifting at each bit
            // boundary presents the next data bit, LSB first.
            DATA: begin
                if (sample_tick) begin
                    tickCnt_d = bitDone ? '0 : tickCnt_q + TICK_W'(1);
                end
                if (bitDone) begin
                    shift_d = shift_q >> 1;
                    if (bitCnt_q == DATA_LAST) begin
                        bitCnt_d = '0;
                        state_d  = STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + BIT_W'(1);
                    end
                end
            end

            // At the end of the last stop bit the next character is loaded
            // directly, so consecutive frames abut with no idle cycle.
            STOP: begin
                if (sample_tick) begin
                    tickCnt_d = bitDone ? '0 : tickCnt_q + TICK_W'(1);
                end
                if (bitDone) begin
                    if (bitCnt_q == STOP_LAST) begin
                        tickCnt_d = '0;
                        bitCnt_d  = '0;
`ifdef UART_TX_BREAK_EN
                        if (break_req) begin
                            state_d = BREAK;
                        end else
`endif
                        if (!fifoEmpty) begin
                            popFifo = 1'b1;
                            shift_d = headData;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + BIT_W'(1);
                    end
                end
            end

`ifdef UART_TX_BREAK_EN
            // Hold the line low without touching the FIFO; queued characters
            // wait until the break is released and the FSM is back in IDLE.
            BREAK: begin
                tickCnt_d = '0;
                bitCnt_d  = '0;
                if (!break_req) begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d   = IDLE;
                tickCnt_d = '0;
                bitCnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Line level for the next cycle, decoded from the next state so the
    // output flop changes exactly when the state does and tx_serial never
    // passes through combinational logic.
    // ------------------------------------------------------------------------
    always_comb begin
        txSerial_d = 1'b1;
        case (state_d)
            START:   txSerial_d = 1'b0;
            DATA:    txSerial_d = shift_d[0];
`ifdef UART_TX_BREAK_EN
            BREAK:   txSerial_d = 1'b0;
`endif
            default: txSerial_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM and datapath registers. Reset forces the line high immediately,
    // even in the middle of a frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            txSerial_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            txSerial_q <= txSerial_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_serial      = txSerial_q;
    assign wr_full        = fifoFull;
    assign tx_empty       = fifoEmpty;
    assign tx_level       = level_q;
    assign tx_active      = (state_q != IDLE);
    assign overflow_error = overflow_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ============================================================================
// tb_uart_tx_engine
// ----------------------------------------------------------------------------
// Self-checking bench for uart_tx_engine. Accepted characters are pushed onto
// an expected-transmit queue; an independent line monitor recognises each
// frame on tx_serial, pops the queue and checks the frame bit by bit against
// the character's ideal waveform (start 0, data LSB first, stop 1, each bit
// OVERSAMPLE_RATE ticks long).
// ============================================================================
`timescale 1ns/1ps

module tb_uart_tx_engine;

    localparam int FIFO_DEPTH      = 8;
    localparam int DATA_WIDTH      = 8;
    localparam int OVERSAMPLE_RATE = 16;
    localparam int STOP_BITS       = 1;
    localparam int FRAME_BITS      = 1 + DATA_WIDTH + STOP_BITS;
    localparam int FRAME_TICKS     = FRAME_BITS * OVERSAMPLE_RATE;
    localparam int LVL_W           = $clog2(FIFO_DEPTH) + 1;

    logic                  uart_clk    = 1'b0;
    logic                  uart_rst_n  = 1'b0;
    logic                  sample_tick = 1'b0;
    logic [DATA_WIDTH-1:0] wr_data     = '0;
    logic                  wr_en       = 1'b0;
    logic                  fifo_clear  = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic                  break_req   = 1'b0;
`endif
    logic                  tx_serial;
    logic                  wr_full;
    logic                  tx_empty;
    logic [LVL_W-1:0]      tx_level;
    logic                  tx_active;
    logic                  overflow_error;

    uart_tx_engine #(
        .FIFO_DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .OVERSAMPLE_RATE (OVERSAMPLE_RATE),
        .STOP_BITS       (STOP_BITS)
    ) dut (
        .uart_clk       (uart_clk),
        .uart_rst_n     (uart_rst_n),
        .sample_tick    (sample_tick),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .fifo_clear     (fifo_clear),
`ifdef UART_TX_BREAK_EN
        .break_req      (break_req),
`endif
        .tx_serial      (tx_serial),
        .wr_full        (wr_full),
        .tx_empty       (tx_empty),
        .tx_level       (tx_level),
        .tx_active      (tx_active),
        .overflow_error (overflow_error)
    );

    // Scoreboard and bookkeeping
    int                    testsRun     = 0;
    int                    testsFailed  = 0;
    int                    cyc          = 0;
    int                    framesDone   = 0;
    int                    activeCnt    = 0;
    int                    lastIssueCyc = 0;
    bit                    tickRandom   = 1'b0;
    bit                    monitorEn    = 1'b1;
    logic [DATA_WIDTH-1:0] expQ[$];
    int                    startCycQ[$];
    int                    levelAtStartQ[$];

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    always #5 uart_clk = ~uart_clk;

    always @(posedge uart_clk) cyc <= cyc + 1;

    // Oversample strobe: every cycle, or a random ~50% duty when enabled.
    initial begin
        forever begin
            @(posedge uart_clk);
            #1;
            sample_tick = tickRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    always @(negedge uart_clk) begin
        if (tx_active === 1'b1) activeCnt++;
    end

    // Global time limit so the run can never hang.
    initial begin
        #(5_000_000);
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 5000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------------
    // Line monitor: finds frames on tx_serial and checks them against the
    // expected-transmit queue.
    // ------------------------------------------------------------------------
    typedef enum {M_WAIT, M_FRAME} mstate_t;
    mstate_t               mState = M_WAIT;
    int                    mTicks;
    int                    mBitIdx;
    int                    mShapeErr;
    bit                    mHaveExp;
    logic                  mExpBit;
    logic [DATA_WIDTH-1:0] mExp;
    logic [DATA_WIDTH-1:0] mGot;

    always @(negedge uart_clk) begin
        if (!uart_rst_n || !monitorEn) begin
            mState = M_WAIT;
        end else begin
            if (mState == M_WAIT && tx_serial === 1'b0) begin
                mState    = M_FRAME;
                mTicks    = 0;
                mShapeErr = 0;
                mGot      = '0;
                startCycQ.push_back(cyc);
                levelAtStartQ.push_back(int'(tx_level));
                if (expQ.size() == 0) begin
                    mHaveExp = 1'b0;
                    mExp     = '0;
                end else begin
                    mHaveExp = 1'b1;
                    mExp     = expQ.pop_front();
                end
            end
            if (mState == M_FRAME) begin
                mBitIdx = mTicks / OVERSAMPLE_RATE;
                if (mBitIdx == 0)               mExpBit = 1'b0;
                else if (mBitIdx <= DATA_WIDTH) mExpBit = mExp[mBitIdx-1];
                else                            mExpBit = 1'b1;
                if (tx_serial !== mExpBit || tx_active !== 1'b1) mShapeErr++;
                if (sample_tick && (mTicks % OVERSAMPLE_RATE) == OVERSAMPLE_RATE / 2 &&
                    mBitIdx >= 1 && mBitIdx <= DATA_WIDTH) begin
                    mGot[mBitIdx-1] = tx_serial;
                end
                if (sample_tick) mTicks++;
                if (mTicks == FRAME_TICKS) begin
                    mState = M_WAIT;
                    framesDone++;
                    checkOutput("frame_expected", 32'(mHaveExp), 32'd1);
                    checkOutput("frame_data", 32'(mGot), 32'(mExp));
                    checkOutput("frame_shape_errors", 32'(mShapeErr), 32'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers. All are entered and left 1 ns after a rising edge.
    // The reference model is the expected-transmit queue: a push is accepted
    // while fewer than FIFO_DEPTH characters are waiting, a flush empties it.
    // ------------------------------------------------------------------------
    task automatic applyStimulus(input logic [DATA_WIDTH-1:0] d, input logic doPush,
                                 input logic doClear);
        wr_data    = d;
        wr_en      = doPush;
        fifo_clear = doClear;
        @(posedge uart_clk);
        if (doClear) begin
            expQ.delete();
        end else if (doPush && expQ.size() < FIFO_DEPTH) begin
            expQ.push_back(d);
        end
        #1;
        wr_en        = 1'b0;
        fifo_clear   = 1'b0;
        lastIssueCyc = cyc;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    task automatic waitIdle(input string name, input int budget);
        bit reached = 1'b0;
        for (int i = 0; i < budget && !reached; i++) begin
            idleCycles(1);
            if (expQ.size() == 0 && mState == M_WAIT && tx_active === 1'b0 &&
                tx_empty === 1'b1) begin
                reached = 1'b1;
            end
        end
        checkOutput(name, 32'(reached), 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int f0;
        int lowCnt;

        // Reset state
        idleCycles(3);
        checkOutput("rst_tx_serial", 32'(tx_serial), 32'd1);
        checkOutput("rst_tx_level", 32'(tx_level), 32'd0);
        checkOutput("rst_tx_empty", 32'(tx_empty), 32'd1);
        checkOutput("rst_wr_full", 32'(wr_full), 32'd0);
        checkOutput("rst_tx_active", 32'(tx_active), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_error), 32'd0);
        uart_rst_n = 1'b1;
        idleCycles(2);

        // Single 0xA5 frame with a tick every cycle
        startCycQ.delete();
        activeCnt = 0;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        waitIdle("a5_drain", 400);
        checkOutput("a5_active_cycles", 32'(activeCnt), 32'd160);
        checkOutput("a5_frame_count", 32'(startCycQ.size()), 32'd1);
        if (startCycQ.size() >= 1) begin
            checkOutput("a5_start_latency", 32'(startCycQ[0] - lastIssueCyc), 32'd1);
        end
        checkOutput("a5_idle_line", 32'(tx_serial), 32'd1);

        // Three back-to-back characters queued behind a frame in flight
        startCycQ.delete();
        levelAtStartQ.delete();
        applyStimulus(8'h7E, 1'b1, 1'b0);
        idleCycles(20);
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h02, 1'b1, 1'b0);
        applyStimulus(8'h03, 1'b1, 1'b0);
        checkOutput("b2b_level_3", 32'(tx_level), 32'd3);
        waitIdle("b2b_drain", 1200);
        checkOutput("b2b_frame_count", 32'(startCycQ.size()), 32'd4);
        if (startCycQ.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                checkOutput($sformatf("b2b_gap_%0d", i),
                            32'(startCycQ[i] - startCycQ[i-1]), 32'(FRAME_TICKS));
                checkOutput($sformatf("b2b_level_after_pop_%0d", i),
                            32'(levelAtStartQ[i]), 32'(3 - i));
            end
        end
        checkOutput("b2b_empty_after_third", 32'(tx_empty), 32'd1);

        // Overflow: nine pushes while a frame is in flight
        f0 = framesDone;
        applyStimulus(8'h33, 1'b1, 1'b0);
        idleCycles(5);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'(8'h10 + i), 1'b1, 1'b0);
            if (i == 7) begin
                checkOutput("ovf_full_at_8", 32'(wr_full), 32'd1);
                checkOutput("ovf_flag_before_drop", 32'(overflow_error), 32'd0);
            end
        end
        checkOutput("ovf_flag_set", 32'(overflow_error), 32'd1);
        checkOutput("ovf_level_8", 32'(tx_level), 32'd8);
        checkOutput("ovf_full", 32'(wr_full), 32'd1);
        waitIdle("ovf_drain", 2000);
        checkOutput("ovf_frames_sent", 32'(framesDone - f0), 32'd9);
        checkOutput("ovf_flag_sticky", 32'(overflow_error), 32'd1);

        // Flush mid-frame with five entries waiting
        f0 = framesDone;
        applyStimulus(8'h44, 1'b1, 1'b0);
        idleCycles(5);
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h60 + i), 1'b1, 1'b0);
        checkOutput("clr_level_5", 32'(tx_level), 32'd5);
        applyStimulus(8'h99, 1'b1, 1'b1);
        checkOutput("clr_level_0", 32'(tx_level), 32'd0);
        checkOutput("clr_overflow_0", 32'(overflow_error), 32'd0);
        checkOutput("clr_frame_continues", 32'(tx_active), 32'd1);
        waitIdle("clr_drain", 400);
        checkOutput("clr_frames_sent", 32'(framesDone - f0), 32'd1);
        idleCycles(40);
        checkOutput("clr_line_idle", 32'(tx_serial), 32'd1);
        checkOutput("clr_inactive", 32'(tx_active), 32'd0);

        // Reset during data bit 3 (0xA5 has bit 3 = 0)
        applyStimulus(8'hA5, 1'b1, 1'b0);
        applyStimulus(8'hC3, 1'b1, 1'b0);
        idleCycles(70);
        checkOutput("rstmid_line_low", 32'(tx_serial), 32'd0);
        checkOutput("rstmid_active_before", 32'(tx_active), 32'd1);
        #2;
        uart_rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("rstmid_tx_serial", 32'(tx_serial), 32'd1);
        checkOutput("rstmid_tx_level", 32'(tx_level), 32'd0);
        checkOutput("rstmid_tx_active", 32'(tx_active), 32'd0);
        checkOutput("rstmid_tx_empty", 32'(tx_empty), 32'd1);
        idleCycles(3);
        uart_rst_n = 1'b1;
        idleCycles(3);

        // Randomised traffic with an irregular oversample strobe. Pushes keep
        // a margin below full so acceptance is always certain.
        f0 = framesDone;
        tickRandom = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3 && expQ.size() < FIFO_DEPTH - 2) begin
                applyStimulus(DATA_WIDTH'($urandom), 1'b1, 1'b0);
            end else begin
                idleCycles(1);
            end
        end
        waitIdle("rand_drain", 6000);
        checkOutput("rand_frames_nonzero", 32'(framesDone > f0), 32'd1);
        tickRandom = 1'b0;
        idleCycles(2);

`ifdef UART_TX_BREAK_EN
        // Break held for 200 cycles with 0x55 queued behind it
        f0 = framesDone;
        monitorEn = 1'b0;
        break_req = 1'b1;
        applyStimulus(8'h55, 1'b1, 1'b0);
        lowCnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge uart_clk);
            if (tx_serial === 1'b0) lowCnt++;
        end
        checkOutput("brk_low_cycles", 32'(lowCnt), 32'd200);
        checkOutput("brk_char_held", 32'(tx_level), 32'd1);
        break_req = 1'b0;
        @(negedge uart_clk);
        #1;
        checkOutput("brk_release_line", 32'(tx_serial), 32'd1);
        monitorEn = 1'b1;
        waitIdle("brk_drain", 400);
        checkOutput("brk_char_sent", 32'(framesDone - f0), 32'd1);
`else
        lowCnt = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries (power of 2, at least 2).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per character.
REQ-003 The block SHALL have parameter OVERSAMPLE_RATE, default 16, meaning sample_ticks per bit.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 and 2).
REQ-005 The block SHALL have these ports, each given as name, direction, width and meaning:
- uart_clk  in  1  clock
- uart_rst_n  in  1  reset: asynchronous, active-low
- sample_tick  in  1  one-cycle oversample strobe
- wr_data  in  DATA_WIDTH  character to queue
- wr_en  in  1  push request
- fifo_clear  in  1  synchronous FIFO flush
- tx_serial  out  1  serial line, idle high
- wr_full  out  1  FIFO full
- tx_empty  out  1  FIFO empty
- tx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- tx_active  out  1  frame in progress
- overflow_error  out  1  sticky: push dropped

Function
REQ-006 The FIFO SHALL be synchronous to uart_clk, store characters first-in first-out, and wrap its pointers modulo FIFO_DEPTH.
REQ-007 A push with wr_en=1 and wr_full=0 SHALL store wr_data, and tx_level SHALL increment on the next cycle.
REQ-008 A push with wr_en=1 and wr_full=1 SHALL be dropped and SHALL set overflow_error on the next cycle.
REQ-009 A push and a pop in the same cycle SHALL leave tx_level unchanged; a push while full SHALL still be dropped, even if a pop occurs in that cycle.
REQ-010 The block SHALL derive wr_full as tx_level==FIFO_DEPTH and tx_empty as tx_level==0, both combinationally from registered state.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-012 In IDLE with tx_empty=0, the FSM SHALL pop one entry into the shift register, clear the tick and bit counters, and enter START; tx_serial SHALL be 0 from the next cycle.
REQ-013 Each bit SHALL last exactly OVERSAMPLE_RATE sample_ticks; the tick counter SHALL advance only on sample_tick and the bit SHALL end on the tick where the counter equals OVERSAMPLE_RATE-1.
REQ-014 START SHALL drive tx_serial=0 for one bit period and then enter DATA.
REQ-015 DATA SHALL drive DATA_WIDTH bits LSB first, shifting once per bit, and SHALL enter STOP after bit DATA_WIDTH-1.
REQ-016 STOP SHALL drive tx_serial=1 for STOP_BITS×OVERSAMPLE_RATE ticks.
REQ-017 At the end of STOP, the FSM SHALL pop the next entry and go directly to START if tx_empty=0, with no idle gap, and SHALL otherwise go to IDLE.
REQ-018 tx_active SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-019 fifo_clear SHALL empty the FIFO on the next cycle; a push in the same cycle SHALL be discarded without setting overflow_error.
REQ-020 fifo_clear SHALL clear overflow_error and SHALL NOT abort the frame currently being shifted.
REQ-021 A pop coincident with fifo_clear SHALL take the head entry, which SHALL then be transmitted in full.
REQ-022 tx_serial SHALL be driven from a register and SHALL be glitch-free.

Reset
REQ-023 Reset SHALL use uart_rst_n, asynchronous, active-low, on clock uart_clk.
REQ-024 Reset SHALL give tx_serial=1, state IDLE, pointers 0, tx_level=0, tx_empty=1, wr_full=0, tx_active=0, overflow_error=0, counters 0 and shift register 0.
REQ-025 Reset asserted mid-frame SHALL return tx_serial to 1 immediately and SHALL discard FIFO contents.

Configuration
REQ-026 With UART_TX_BREAK_EN defined, the block SHALL add input break_req (1 bit) and a BREAK state.
REQ-027 With UART_TX_BREAK_EN defined, break_req=1 in IDLE SHALL enter BREAK, which holds tx_serial=0 and tx_active=1 and does not pop, and break_req=0 SHALL return the FSM to IDLE with tx_serial=1 on the next cycle.
REQ-028 With UART_TX_BREAK_EN defined, break_req asserted mid-frame SHALL take effect only after STOP completes, with BREAK taking priority over popping the next entry.
REQ-029 Without UART_TX_BREAK_EN, the break_req port and the BREAK state SHALL be absent, and behaviour SHALL be exactly as REQ-006 to REQ-025.

Verification
REQ-030 The bench SHALL push 0xA5 with sample_tick every cycle and check that tx_serial is 0 for 16 cycles, then 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16 cycles; tx_active SHALL be high for 160 cycles.
REQ-031 The bench SHALL push 0x01, 0x02 and 0x03 back-to-back and check three contiguous frames with no idle gap, tx_level stepping 3→2→1→0, and tx_empty=1 after the third pop.
REQ-032 The bench SHALL push 9 characters (0x10..0x18) while a frame is in flight at FIFO_DEPTH=8 and check wr_full=1, the 9th push dropped, overflow_error=1, and 0x10..0x17 transmitted.
REQ-033 The bench SHALL assert fifo_clear mid-frame while tx_level=5 and check the current frame completes, tx_level=0, overflow_error=0, and the line goes idle afterwards.
REQ-034 The bench SHALL assert uart_rst_n low during DATA bit 3 and check tx_serial=1, tx_level=0 and tx_active=0 immediately.
REQ-035 With UART_TX_BREAK_EN defined, the bench SHALL hold break_req for 200 cycles in IDLE and check tx_serial=0 for 200 cycles, then 1, with the queued 0x55 sent only after release.
